// File: rtl/apb_pkg.sv
// Shared APB types for the requester and completer sides of the subsystem.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_t;

  // Wait-counter width: holds 0..TIMEOUT_CYCLES, at least one bit when disabled.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB bus seen by the APB requester.
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_write;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [DATA_WIDTH-1:0] i_cmd_wdata;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_rsp_timeout;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PSELx;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output PADDR, PWRITE, PWDATA, PSELx, PENABLE
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  PADDR, PWRITE, PWDATA, PSELx, PENABLE
  );
endinterface

// File: rtl/apb_master_timer.sv
// ACCESS-phase wait counter; flags the last allowed wait cycle before abort.
module apb_master_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = timer_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at all-ones so a disabled or long-stalled count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one SETUP/ACCESS transfer per command, one response per transfer.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  apb_master_if.master bus
);

  localparam logic [1:0] ST_IDLE   = APB_IDLE;
  localparam logic [1:0] ST_SETUP  = APB_SETUP;
  localparam logic [1:0] ST_ACCESS = APB_ACCESS;
  localparam logic [1:0] ST_RESP   = APB_RESP;

  logic [1:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
  logic                  err_q,       err_d;
  logic                  timeout_q,   timeout_d;

  logic accept, tmr_expired;

  assign accept = (state_q == ST_IDLE) && bus.i_cmd_valid;

  apb_master_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (accept),
    .i_enable  ((state_q == ST_ACCESS) && !bus.PREADY),
    .o_expired (tmr_expired)
  );

  // Outputs are computed from next state so every bus/response pin comes from a flop.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          paddr_d     = bus.i_cmd_addr;
          pwrite_d    = bus.i_cmd_write;
          pwdata_d    = bus.i_cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A completing PREADY wins over a timeout landing on the same edge.
        if (bus.PREADY) begin
          rdata_d     = pwrite_q ? '0 : bus.PRDATA;
          err_d       = bus.PSLVERR;
          timeout_d   = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (tmr_expired) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          timeout_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rdata_q;
  assign bus.o_rsp_err     = err_q;
  assign bus.o_rsp_timeout = timeout_q;
  assign bus.PADDR         = paddr_q;
  assign bus.PWRITE        = pwrite_q;
  assign bus.PWDATA        = pwdata_q;
  assign bus.PSELx         = psel_q;
  assign bus.PENABLE       = penable_q;

`ifdef FORMAL
  logic f_outstanding_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                              f_outstanding_q <= 1'b0;
    else if (bus.o_cmd_ready && bus.i_cmd_valid) f_outstanding_q <= 1'b1;
    else if (bus.o_rsp_valid && bus.i_rsp_ready) f_outstanding_q <= 1'b0;
  end

  a_apb_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bus.PSELx |=> (!bus.PSELx || ($stable(bus.PADDR) && $stable(bus.PWRITE) && $stable(bus.PWDATA))));
  a_enable_after_setup: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $rose(bus.PENABLE) |-> $past(bus.PSELx && !bus.PENABLE));
  a_single_outstanding: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (bus.o_cmd_ready && bus.i_cmd_valid) |-> !f_outstanding_q);
  a_rsp_has_cmd: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bus.o_rsp_valid |-> f_outstanding_q);
`endif

endmodule
